uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx transmitter between NUM_REQ byte-stream requesters, e.g. the echo path, status/debug message generators and command responses.
- Grants are packet-locked: once a requester wins, it owns the transmitter until it sends a byte flagged last. This keeps messages from interleaving on the wire.
- Arbitration between packets is round-robin.
- Sits between the requesters and uart_tx. It drives uart_tx data/valid and watches uart_tx ready.

Parameters:
- NUM_REQ, 4, number of requesters (1..8; need not be a power of 2).
- TIMEOUT_CYCLES, 1024, idle-lock timeout in clk cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock (12 MHz)
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid
- req_ready  out  NUM_REQ  per-requester accept; a byte transfers when req_valid[i] & req_ready[i]
- tx_data  out  8  byte to uart_tx.data
- tx_valid  out  1  one-cycle start pulse to uart_tx.valid
- tx_ready  in  1  uart_tx.ready (1 = transmitter idle)
- grant_id  out  $clog2(NUM_REQ) (min 1)  current or last granted requester
- busy  out  1  1 while a grant is held
- timeout_pulse  out  1  one-cycle pulse when a lock is broken by timeout

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, tx_valid=0, tx_data=8'h00, grant_id=0, rr_ptr=0, busy=0, req_ready=0, timeout_pulse=0.
- Reset asserted mid-packet aborts the packet immediately. If tx_valid was high, it drops asynchronously.
- States:
  - IDLE: req_ready=0. If tx_ready=1 and any req_valid=1, pick the winner: the first requester with req_valid set, searching from rr_ptr upward with wrap (NUM_REQ-1 wraps to 0). Register it into grant_id, set busy=1, go to LOCKED. Otherwise stay in IDLE.
  - LOCKED: req_ready[grant_id]=tx_ready; all other req_ready bits are 0. On a transfer, register tx_data from the granted requester's req_data, register last_flag from its req_last, and go to ISSUE. With no transfer, stay in LOCKED.
  - ISSUE: tx_valid=1 for exactly this one cycle; req_ready=0. Always go to SETTLE.
  - SETTLE: one cycle, tx_ready ignored; this covers uart_tx's registered ready. req_ready=0. Always go to DRAIN.
  - DRAIN: req_ready=0. Wait for tx_ready=1.
    - If last_flag=1: go to IDLE, busy=0, rr_ptr=(grant_id+1) mod NUM_REQ.
    - Otherwise: go to LOCKED.
- Latency:
  - A byte accepted at edge T has tx_valid=1 and tx_data valid during cycle T..T+1.
  - The next byte of the same packet is accepted no earlier than 3 cycles later; in practice accepts are paced by uart_tx.
- tx_data holds its value until the next transfer. grant_id holds after release.
- Single-byte packet (req_last=1 on the first byte): released after its DRAIN.
- Granted requester drops req_valid mid-packet: the lock is kept and other requesters wait.
- Simultaneous requests in IDLE: resolved by rr_ptr only. A requester never wins twice in a row while another has req_valid held.
- tx_ready=0 while in IDLE: no grant is made.
- NUM_REQ=1: rr_ptr stays 0 and packets still go through the full handshake.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A counter increments each LOCKED cycle with req_valid[grant_id]=0, and clears on any transfer or on leaving LOCKED.
  - When it reaches TIMEOUT_CYCLES-1 in LOCKED: go to IDLE, busy=0, rr_ptr=(grant_id+1) mod NUM_REQ, timeout_pulse=1 for one cycle.
  - A timeout never fires in ISSUE, SETTLE or DRAIN.
- When undefined: no counter; timeout_pulse is tied to 0 and a lock is held indefinitely.

Test Plan:
1. Reset: hold rst_n=0 with req_valid=4'hF. Required: tx_valid=0, req_ready=0, busy=0, grant_id=0. After release with tx_ready=1, requester 0 is granted the next cycle.
2. Single packet: requester 2 sends 8'h41, 8'h42, 8'h43 (last on 8'h43) against a uart_tx model holding ready low for 10 cycles.
   - Exactly 3 tx_valid pulses with tx_data 41, 42, 43.
   - busy falls after the third DRAIN; rr_ptr=3.
3. Contention: requesters 0 and 1 each hold valid with 2-byte packets ('A','B' and 'x','y').
   - Wire order is A B x y, then A B again; there is no interleave.
   - grant_id sequence is 0, 1, 0.
4. Wrap: NUM_REQ=3, only requester 2 requesting repeatedly with 1-byte packets 8'h55. Each grant goes to 2 and rr_ptr wraps to 0 after each packet.
5. Reset mid-packet: assert rst_n=0 during ISSUE of byte 2 of 4.
   - tx_valid drops immediately.
   - After release, the arbiter is in IDLE and a new grant starts from requester 0.
6. With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: requester 1 sends one non-last byte then drops valid.
   - timeout_pulse=1 for one cycle, 16 cycles after DRAIN completes.
   - A pending requester 3 is granted next.
   - Without the macro, the same stimulus keeps busy=1 indefinitely.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart_tx between NUM_REQ byte streams.
// Optional idle-lock timeout is compiled in when ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 timeout_pulse
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOCKED = 3'd1,
        ISSUE  = 3'd2,
        SETTLE = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] next_ptr;
    logic          last_flag;

    logic          pick_found;
    logic [GW-1:0] pick_id;
    int            idx;

    logic          granted_valid;
    logic          granted_last;
    logic [7:0]    granted_data;
    logic          xfer;
    logic          timeout_hit;

    assign granted_valid = req_valid[grant_id];
    assign granted_last  = req_last[grant_id];
    assign granted_data  = req_data[8*grant_id +: 8];
    assign xfer          = (state == LOCKED) && tx_ready && granted_valid;
    assign next_ptr      = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Round-robin search: walking offsets downward leaves the nearest valid
    // requester at or after rr_ptr as the final winner.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[GW'(idx)]) begin
                pick_found = 1'b1;
                pick_id    = GW'(idx);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tx_ready && pick_found) state_next = LOCKED;
            LOCKED:  begin
                if (xfer)             state_next = ISSUE;
                else if (timeout_hit) state_next = IDLE;
            end
            ISSUE:   state_next = SETTLE;
            SETTLE:  state_next = DRAIN;
            DRAIN:   if (tx_ready) state_next = last_flag ? IDLE : LOCKED;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state alone, so an async reset drops tx_valid at once.
    always_comb begin
        req_ready = '0;
        tx_valid  = 1'b0;
        case (state)
            LOCKED:  req_ready[grant_id] = tx_ready;
            ISSUE:   tx_valid = 1'b1;
            default: ;
        endcase
    end

    // Grant, round-robin pointer and byte registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id  <= '0;
            rr_ptr    <= '0;
            busy      <= 1'b0;
            tx_data   <= 8'h00;
            last_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_ready && pick_found) begin
                        grant_id <= pick_id;
                        busy     <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        tx_data   <= granted_data;
                        last_flag <= granted_last;
                    end else if (timeout_hit) begin
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
                end
                DRAIN: begin
                    if (tx_ready && last_flag) begin
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int            CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] idle_cnt;
    logic          pulse_q;

    // Counts LOCKED cycles in which the owner has nothing to offer.
    assign timeout_hit   = (state == LOCKED) && !granted_valid && (idle_cnt == TO_LAST);
    assign timeout_pulse = pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            pulse_q  <= 1'b0;
        end else begin
            pulse_q <= timeout_hit;
            if (state != LOCKED || xfer) idle_cnt <= '0;
            else if (!granted_valid)     idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign timeout_pulse      = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule
